// File: rtl/simple_circuit_reg.sv
// Bit-wise gate network D = (A & B) | ~C, E = ~C with combinational and registered outputs.
// Optional lane-0 pattern coverage bitmap enabled by SIMPLE_CIRCUIT_COV_EN.
module simple_circuit_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d_comb,
    output logic [WIDTH-1:0] e_comb,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic             out_valid,
    output logic [7:0]       cov,
    output logic             cov_full
);

    assign d_comb = (a & b) | ~c;
    assign e_comb = ~c;

    // d/e only move on a qualified capture so idle inputs never leak through
    always_ff @(posedge clk) begin
        if (rst) begin
            d         <= '0;
            e         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d <= d_comb;
                e <= e_comb;
            end
        end
    end

`ifdef SIMPLE_CIRCUIT_COV_EN
    // Index is {a,b,c} of lane 0 with A as MSB; bits are sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cov <= 8'h00;
        end else if (in_valid) begin
            cov[{a[0], b[0], c[0]}] <= 1'b1;
        end
    end

    assign cov_full = &cov;
`else
    assign cov      = 8'h00;
    assign cov_full = 1'b0;
`endif

endmodule

// File: tb/tb_simple_circuit_reg.sv
// Self-checking bench: WIDTH=1 and WIDTH=4 instances driven in lockstep against a truth-table model.
module tb_simple_circuit_reg;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [0:0] a1, b1, c1;
    logic [3:0] a4, b4, c4;

    logic [0:0] d_comb1, e_comb1, d1, e1;
    logic [3:0] d_comb4, e_comb4, d4, e4;
    logic       ov1, ov4, cf1, cf4;
    logic [7:0] cov1, cov4;

    int total = 0;
    int bad   = 0;

    // {D,E} per {A,B,C} index, straight from the truth table
    logic [1:0] tt [0:7] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10};

    logic [0:0] m_d1, m_e1;
    logic [3:0] m_d4, m_e4;
    logic       m_v;
    logic [7:0] m_cov1, m_cov4;

    simple_circuit_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a1), .b(b1), .c(c1),
        .d_comb(d_comb1), .e_comb(e_comb1), .d(d1), .e(e1),
        .out_valid(ov1), .cov(cov1), .cov_full(cf1)
    );

    simple_circuit_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a4), .b(b4), .c(c4),
        .d_comb(d_comb4), .e_comb(e_comb4), .d(d4), .e(e4),
        .out_valid(ov4), .cov(cov4), .cov_full(cf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lanes_d(input logic [3:0] a, b, c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = tt[{a[i], b[i], c[i]}][1];
        return r;
    endfunction

    function automatic logic [3:0] lanes_e(input logic [3:0] a, b, c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = tt[{a[i], b[i], c[i]}][0];
        return r;
    endfunction

    function automatic logic [7:0] exp_cov(input logic [7:0] m);
`ifdef SIMPLE_CIRCUIT_COV_EN
        return m;
`else
        return 8'h00 & m;
`endif
    endfunction

    // Called at a negedge: drives inputs, checks comb, clocks the model, checks registers
    task automatic step(input logic r, input logic v, input logic [0:0] ia1, ib1, ic1,
                        input logic [3:0] ia4, ib4, ic4);
        rst = r; in_valid = v;
        a1 = ia1; b1 = ib1; c1 = ic1;
        a4 = ia4; b4 = ib4; c4 = ic4;
        #1;
        chk("d_comb1", 32'(d_comb1), 32'(tt[{ia1, ib1, ic1}][1]));
        chk("e_comb1", 32'(e_comb1), 32'(tt[{ia1, ib1, ic1}][0]));
        chk("d_comb4", 32'(d_comb4), 32'(lanes_d(ia4, ib4, ic4)));
        chk("e_comb4", 32'(e_comb4), 32'(lanes_e(ia4, ib4, ic4)));
        @(posedge clk);
        if (r) begin
            m_d1 = '0; m_e1 = '0; m_d4 = '0; m_e4 = '0; m_v = 1'b0;
            m_cov1 = 8'h00; m_cov4 = 8'h00;
        end else if (v) begin
            m_d1 = tt[{ia1, ib1, ic1}][1];
            m_e1 = tt[{ia1, ib1, ic1}][0];
            m_d4 = lanes_d(ia4, ib4, ic4);
            m_e4 = lanes_e(ia4, ib4, ic4);
            m_v  = 1'b1;
            m_cov1[{ia1, ib1, ic1}] = 1'b1;
            m_cov4[{ia4[0], ib4[0], ic4[0]}] = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        @(negedge clk);
        chk("d1", 32'(d1), 32'(m_d1));
        chk("e1", 32'(e1), 32'(m_e1));
        chk("out_valid1", 32'(ov1), 32'(m_v));
        chk("d4", 32'(d4), 32'(m_d4));
        chk("e4", 32'(e4), 32'(m_e4));
        chk("out_valid4", 32'(ov4), 32'(m_v));
        chk("cov1", 32'(cov1), 32'(exp_cov(m_cov1)));
        chk("cov_full1", 32'(cf1), 32'(exp_cov(m_cov1) == 8'hFF));
        chk("cov4", 32'(cov4), 32'(exp_cov(m_cov4)));
        chk("cov_full4", 32'(cf4), 32'(exp_cov(m_cov4) == 8'hFF));
    endtask

    initial begin
        logic [2:0] idx;
        rst = 1'b1; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 4'hF;
        m_d1 = '0; m_e1 = '0; m_d4 = '0; m_e4 = '0; m_v = 1'b0;
        m_cov1 = 8'h00; m_cov4 = 8'h00;
        @(negedge clk);

        // Reset with valid 111 applied: registered outputs stay cleared
        step(1, 1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF);
        step(1, 1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF);
        chk("reset_d1_literal", 32'(d1), 32'd0);
        chk("reset_dcomb1_literal", 32'(d_comb1), 32'd1);

        // Exhaustive sweep on lane 0, random on the 4-lane instance
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            step(0, 1, idx[2], idx[1], idx[0], 4'($urandom), 4'($urandom), {3'($urandom), idx[0]});
        end
        chk("sweep_last_de1", 32'({d1, e1}), 32'h2);
        chk("sweep_cov1", 32'(cov1), 32'(exp_cov(8'hFF)));

        // Hold with in_valid low and 000 on the inputs
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("hold_de1", 32'({d1, e1}), 32'h2);

        // Directed multi-lane vector
        step(0, 1, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b1010, 4'b0110);
        chk("multi_d4", 32'(d4), 32'(4'b1001));
        chk("multi_e4", 32'(e4), 32'(4'b1001));

        // Mid-stream reset then resume with 001
        step(0, 1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        step(1, 1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        step(0, 1, 1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 4'h1);
        chk("resume_de1", 32'({d1, e1}), 32'h0);
        chk("resume_cov1", 32'(cov1), 32'(exp_cov(8'h02)));

        // Random traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        step(1, 0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        chk("final_cov1_cleared", 32'(cov1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_circuit_reg.md
Name: simple_circuit_reg

Overview:
- Registered implementation of a small fixed gate network, applied bit-wise across WIDTH lanes:
  - D = (A AND B) OR (NOT C)
  - E = NOT C
- Also provides combinational outputs for zero-latency use, and a valid flag on the registered outputs.
- Leaf block used as a control/decode primitive and as a gate-level sanity vehicle in bring-up benches.

Parameters:
- WIDTH, 1, number of independent bit lanes; each lane evaluates the same gate network on its own a/b/c bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a/b/c for capture this cycle.
- a  input  WIDTH  input A per lane.
- b  input  WIDTH  input B per lane.
- c  input  WIDTH  input C per lane.
- d_comb  output  WIDTH  combinational D = (a & b) | ~c; independent of clk, rst and in_valid.
- e_comb  output  WIDTH  combinational E = ~c; independent of clk, rst and in_valid.
- d  output  WIDTH  registered D.
- e  output  WIDTH  registered E.
- out_valid  output  1  high for one cycle when d/e carry a newly captured result.
- cov  output  8  pattern-coverage bitmap for lane 0 (see Optional Feature).
- cov_full  output  1  high when cov == 8'hFF.

Behaviour:
- Truth table per lane, as {A,B,C} -> {D,E}:
  - 000 -> 11
  - 001 -> 00
  - 010 -> 11
  - 011 -> 00
  - 100 -> 11
  - 101 -> 00
  - 110 -> 11
  - 111 -> 10
- Combinational path:
  - d_comb and e_comb follow the equations above at all times, including during reset.
- Registered path, sampled at each rising clk edge:
  - rst=1: d, e, out_valid and cov all cleared to 0. Reset has priority over in_valid.
  - rst=0, in_valid=1: d <= (a&b)|~c; e <= ~c; out_valid <= 1. Latency is 1 cycle.
  - rst=0, in_valid=0: d and e hold their previous values; out_valid <= 0.
- Back-to-back in_valid: one result per cycle; no stall or backpressure.
- Reset asserted mid-stream: the captured result is discarded and outputs read 0 on the cycle after the reset edge. The first valid input after rst drops produces out_valid=1 one cycle later.
- Lanes are fully independent; no cross-lane logic.
- No X propagation allowed from an uncaptured input: d and e change only on a valid capture or on reset.

Optional Feature:
- Macro: SIMPLE_CIRCUIT_COV_EN.
- Defined:
  - On each clk edge with rst=0 and in_valid=1, set bit cov[{a[0],b[0],c[0]}] (index 0..7, A is the MSB).
  - Bits are sticky until rst.
  - cov_full = &cov.
- Not defined:
  - cov is tied to 8'h00 and cov_full to 0; no coverage flops are synthesized.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid=1, a=b=c=1 -> d=0, e=0, out_valid=0, cov=0. d_comb=1 and e_comb=0 throughout.
- Exhaustive sweep, WIDTH=1: apply {a,b,c}=000..111, one per cycle, in_valid=1.
  - Registered outputs, one cycle later: {d,e} = 11,00,11,00,11,00,11,10, with out_valid=1 each cycle.
  - d_comb/e_comb show the same values in the same cycle as the input.
- Hold: after capturing 111 (d=1, e=0), drop in_valid and drive 000 for 3 cycles -> d=1, e=0 held, out_valid=0; d_comb=1, e_comb=1.
- Coverage with SIMPLE_CIRCUIT_COV_EN:
  - After the full sweep, cov=8'hFF and cov_full=1.
  - A pulse of rst clears cov to 8'h00.
  - Without the macro, cov stays 8'h00 throughout.
- Multi-lane, WIDTH=4: a=4'b1100, b=4'b1010, c=4'b0110 with in_valid=1 -> next cycle d=4'b1001, e=4'b1001.
- Mid-stream reset: rst=1 in the cycle following a capture of 000 -> d=0, e=0, out_valid=0 on the next edge. Resume with 001 -> {d,e}=00 with out_valid=1 one cycle later.
